// File: rtl/accum_pkg.sv
// Shared types and saturation limits for the product accumulator.
package accum_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   function automatic int sat_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_min(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational adder on pre-sign-extended operands; flags when the sum leaves
// the range representable in W-1 bits.
module sat_add #(
   parameter int W = 13
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         sat
);

   assign sum = a + b;
   // Operands carry one guard bit, so a top-bit disagreement means W-1 bits overflowed.
   assign sat = sum[W-1] ^ sum[W-2];

endmodule

// File: rtl/product_accumulator.sv
// Accumulates LEN signed products into a saturating sum and hands each block
// result downstream over a valid/ready handshake.
module product_accumulator
   import accum_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int ACC_W = 12,
   parameter  int LEN   = 8,
   localparam int M     = 2 * N,
   localparam int CNT_W = $clog2(LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [M-1:0]     product,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             overflow,
   output logic [CNT_W-1:0] count
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // a producer holds its data stable until that edge.

   localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
   localparam logic [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic             ovf;
   logic [CNT_W-1:0] cnt;

   logic [ACC_W:0]   ext_acc;
   logic [ACC_W:0]   ext_prod;
   logic [ACC_W:0]   raw_sum;
   logic             step_sat;
   logic [ACC_W-1:0] acc_next;
   logic             accept;

   assign ext_acc  = {acc[ACC_W-1], acc};
   assign ext_prod = {{(ACC_W + 1 - M){product[M-1]}}, product};

   sat_add #(.W(ACC_W + 1)) u_sat_add (
      .a   (ext_acc),
      .b   (ext_prod),
      .sum (raw_sum),
      .sat (step_sat)
   );

   // The guard bit of the exact sum gives the clamp direction.
   assign acc_next = step_sat ? (raw_sum[ACC_W] ? MIN_V : MAX_V) : raw_sum[ACC_W-1:0];

   assign in_ready  = (state == ACCUM) && !clear && !rst;
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ACCUM;
         acc   <= '0;
         ovf   <= 1'b0;
         cnt   <= '0;
      end else if (clear) begin
         state <= ACCUM;
         acc   <= '0;
         ovf   <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  acc <= acc_next;
                  ovf <= ovf | step_sat;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(LEN - 1)) state <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state <= ACCUM;
                  acc   <= '0;
                  ovf   <= 1'b0;
                  cnt   <= '0;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

   assign acc_out  = acc;
   assign overflow = ovf;
   assign count    = cnt;

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of the combinational two's-complement multiplier.
- Consumes its signed 2N-bit product through a valid/ready handshake and accumulates LEN products into a saturating ACC_W-bit accumulator.
- Presents each block sum with a valid/ready output handshake, so dot-product results reach the next stage.

Parameters:
- N, 4, operand width of the upstream multiplier.
- M, 2*N, product width (localparam, not overridable).
- ACC_W, 12, accumulator/result width; must be >= M.
- LEN, 8, products per block; must be >= 1.
- CNT_W, $clog2(LEN+1), sample counter width (localparam).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort/restart of the current block.
- in_valid  in  1  product valid.
- in_ready  out  1  block can accept a product.
- product  in  M  signed two's-complement product from the multiplier.
- out_valid  out  1  block result valid.
- out_ready  in  1  downstream accepts the result.
- acc_out  out  ACC_W  signed block sum (saturated).
- overflow  out  1  a saturation occurred in this block; valid with out_valid.
- count  out  CNT_W  products accepted in the current block.

Behaviour:
- Reset (async, rst=1): state ACCUM; acc_out=0, overflow=0, count=0, out_valid=0, in_ready=0 while rst is high; in_ready=1 from the first cycle after release.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Accept when in_valid && in_ready on a rising edge.
  - On accept: acc <= sat(acc + sext(product)); count <= count+1; overflow |= saturation flag.
  - When the accepted product is the LEN-th (count==LEN-1 before the edge): go to HOLD on that edge.
- State HOLD:
  - in_ready=0, out_valid=1; acc_out, overflow and count=LEN are stable.
  - On out_valid && out_ready: acc<=0, overflow<=0, count<=0, go to ACCUM. ACCUM accepts again on the next cycle.
- Latency: out_valid rises the cycle after the LEN-th accept. Best-case throughput is LEN+1 cycles per block.
- Arithmetic:
  - product is sign-extended to ACC_W+1 bits; the sum is computed at ACC_W+1 bits.
  - If the two top bits differ, clamp to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)) according to the sign of the exact sum, and set the flag.
  - Saturation is per step: once clamped, later products continue from the clamped value.
- clear:
  - Synchronous; highest priority after rst.
  - acc<=0, overflow<=0, count<=0, state ACCUM.
  - A product presented in the same cycle is not accepted: in_ready is forced 0 while clear=1.
  - A pending HOLD result is discarded.
- Simultaneous events:
  - clear beats out_ready and in_valid.
  - In HOLD, in_valid is ignored; the upstream must keep the product stable until in_ready.
  - rst mid-block discards everything immediately.
- LEN=1: every accept goes straight to HOLD.
- acc_out is a registered output, equal to the internal accumulator at all times.
- Unknown or X inputs are not required to be handled.

Decomposition:
- Package accum_pkg:
  - State enum {ACCUM, HOLD}.
  - Functions for saturation limits sat_max(ACC_W) and sat_min(ACC_W).
- One sub-module, sat_add:
  - Combinational, parameter W.
  - Inputs: a[W-1:0] and b[W-1:0] (already sign-extended).
  - Outputs: sum[W-1:0] and sat.
- Top level holds the FSM, counter and registers.

Test Plan:
- Defaults, reset then 8 accepts of product 8'h01 (from 1111*1111) with out_ready=1 -> out_valid one cycle after the 8th accept; acc_out=12'd8, overflow=0, count=8; in_ready=1 next cycle.
- Mixed signs: products +64, -64, +12, -3, 0, 0, 0, 0 -> acc_out=12'd9. With out_ready held 0 for 5 cycles: out_valid and acc_out stay stable, in_ready=0, and in_valid pulses are ignored.
- Saturation with ACC_W=8: products +64, +64, -8, then 5×0 -> steps clamp to 127, then 119. Final acc_out=8'd119, overflow=1. The next block starts with overflow=0.
- Negative saturation with ACC_W=8: 3 × -64, then 5×0 -> 8'h80 (-128), overflow=1.
- clear after 3 accepts of +4 -> count=0 and acc 0 next cycle; in_ready=0 during the clear cycle. The following 8 × +1 give acc_out=8. clear during HOLD drops out_valid with no handshake.
- Assert rst mid-block (after 5 accepts): all outputs 0 asynchronously; a fresh 8-sample block after release gives the correct sum. in_valid gaps (bubbles) do not change the result.
